// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmitter: line-control bit positions,
// FIFO count width, FSM state encoding and small framing helpers.
package uart_transmitter_pkg;

  // Occupancy counter must hold 0..16 for a 16-entry FIFO.
  localparam int FIFO_COUNTER_W = 5;

  // Line control register bit positions ([1:0] is the word length select).
  localparam int LC_SB = 2;
  localparam int LC_PE = 3;
  localparam int LC_EP = 4;
  localparam int LC_SP = 5;
  localparam int LC_BC = 6;

  // Last tick value for a normal 16-tick bit period.
  localparam logic [4:0] BIT_LAST = 5'd15;

  typedef enum logic [2:0] {
    st_idle,
    st_start,
    st_data,
    st_parity,
    st_stop
  } tx_state_e;

  // Index of the final data bit: word length select 0..3 gives 5..8 bits.
  function automatic logic [2:0] last_data_index(input logic [1:0] wls);
    return 3'd4 + {1'b0, wls};
  endfunction

  // Last tick value of the stop period: 16, 24 (1.5 stop on 5-bit) or 32 ticks.
  function automatic logic [4:0] stop_last_tick(input logic sb, input logic [1:0] wls);
    if (!sb)
      return 5'd15;
    else if (wls == 2'b00)
      return 5'd23;
    else
      return 5'd31;
  endfunction

  // acc is the XOR of the data bits actually sent; stick parity ignores it.
  function automatic logic parity_bit(input logic ep, input logic sp, input logic acc);
    if (sp)
      return ~ep;
    else
      return ep ? acc : ~acc;
  endfunction

endpackage

// File: rtl/uart_transmitter_tfifo.sv
// Synchronous TX FIFO for the UART transmitter.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (empties the FIFO)
//   push, data_in  write one entry; dropped with an overrun pulse when full
//   pop          remove the head entry (ignored when empty)
//   data_out     current head entry (combinational read)
//   count        occupancy 0..FIFO_DEPTH
//   overrun      one-clock pulse when a push was dropped
module uart_transmitter_tfifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_W    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic [COUNT_W-1:0] count,
  output logic              overrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              full;
  logic              pop_ok;
  logic              push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count == COUNT_W'(FIFO_DEPTH));
  assign pop_ok   = pop & (count != '0);
  // A pop in the same clock frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push & (~full | pop_ok);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
      overrun <= push & full & ~pop_ok;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers host bytes in a TX FIFO and serialises them on
// stx_pad_o with start/data/parity/stop framing selected by lcr.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   lcr          line control: [1:0] word length, [2] stop, [3] PE, [4] EP, [5] SP, [6] break
//   tf_push, tf_data_in  write one character into the TX FIFO
//   enable       16x baud tick, one clock wide
//   stx_pad_o    serial output, idle high
//   tf_count     TX FIFO occupancy
//   tf_overrun   one-clock pulse when a push was dropped on a full FIFO
//   tx_busy      high from FIFO pop through the last stop tick
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                lcr,
  input  logic                      tf_push,
  input  logic [DATA_W-1:0]         tf_data_in,
  input  logic                      enable,
  output logic                      stx_pad_o,
  output logic [FIFO_COUNTER_W-1:0] tf_count,
  output logic                      tf_overrun,
  output logic                      tx_busy
);

  tx_state_e         state_q, state_d;
  logic [4:0]        tick_q, tick_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [5:0]        flcr_q, flcr_d;
  logic              line_q, line_d;
  logic              start_frame;
  logic              pop;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_lcr;

  // lcr[7] belongs to the register map but plays no part in transmission.
  assign unused_lcr = lcr[7];

  uart_transmitter_tfifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .COUNT_W    (FIFO_COUNTER_W)
  ) u_tfifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tf_push),
    .pop      (pop),
    .data_in  (tf_data_in),
    .data_out (fifo_head),
    .count    (tf_count),
    .overrun  (tf_overrun)
  );

  assign tx_busy = (state_q != st_idle);

  // line_d is the frame level for the next tick; it changes only on baud
  // ticks, and every bit enters by loading tick_d with its last tick value.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_d       = par_q;
    flcr_d      = flcr_q;
    line_d      = line_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    if (enable) begin
      unique case (state_q)
        st_idle: begin
          line_d      = 1'b1;
          start_frame = (tf_count != '0);
        end
        st_start, st_data: begin
          if (tick_q != '0) begin
            tick_d = tick_q - 5'd1;
          end else if (state_q == st_data && bit_q == last_data_index(flcr_q[1:0])) begin
            tick_d = BIT_LAST;
            if (flcr_q[LC_PE]) begin
              state_d = st_parity;
              line_d  = parity_bit(flcr_q[LC_EP], flcr_q[LC_SP], par_q);
            end else begin
              state_d = st_stop;
              line_d  = 1'b1;
              tick_d  = stop_last_tick(flcr_q[LC_SB], flcr_q[1:0]);
            end
          end else begin
            // Next data bit: the start bit hands over to bit 0 here too.
            bit_d   = (state_q == st_start) ? 3'd0 : bit_q + 3'd1;
            state_d = st_data;
            tick_d  = BIT_LAST;
            line_d  = shift_q[0];
            par_d   = par_q ^ shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        st_parity: begin
          if (tick_q != '0) begin
            tick_d = tick_q - 5'd1;
          end else begin
            state_d = st_stop;
            line_d  = 1'b1;
            tick_d  = stop_last_tick(flcr_q[LC_SB], flcr_q[1:0]);
          end
        end
        st_stop: begin
          if (tick_q != '0) begin
            tick_d = tick_q - 5'd1;
          end else if (tf_count != '0) begin
            start_frame = 1'b1;
          end else begin
            state_d = st_idle;
          end
        end
        default: state_d = st_idle;
      endcase

      // Frame setup is shared by idle and the back-to-back stop exit.
      if (start_frame) begin
        pop     = 1'b1;
        state_d = st_start;
        tick_d  = BIT_LAST;
        bit_d   = 3'd0;
        shift_d = fifo_head;
        par_d   = 1'b0;
        flcr_d  = lcr[5:0];
        line_d  = 1'b0;
      end
    end
  end

  // Break overrides the frame line every clock, independent of the baud tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= st_idle;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      flcr_q    <= '0;
      line_q    <= 1'b1;
      stx_pad_o <= 1'b1;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      flcr_q    <= flcr_d;
      line_q    <= line_d;
      stx_pad_o <= lcr[LC_BC] ? 1'b0 : line_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a queue-based line model checked
// every clock, plus hand-computed frame expectations.
module tb_uart_transmitter;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b1;
  logic [7:0] lcr        = 8'h03;
  logic       tf_push    = 1'b0;
  logic [7:0] tf_data_in = 8'h00;
  logic       enable     = 1'b0;
  logic       stx_pad_o;
  logic [4:0] tf_count;
  logic       tf_overrun;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;
  int en_mode  = 0;
  int en_phase = 0;
  int flen;
  logic samples [0:4095];

  uart_transmitter #(.DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcr        (lcr),
    .tf_push    (tf_push),
    .tf_data_in (tf_data_in),
    .enable     (enable),
    .stx_pad_o  (stx_pad_o),
    .tf_count   (tf_count),
    .tf_overrun (tf_overrun),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  // Baud tick: mode 0 off, 1 every clock, 2 every fourth clock.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      en_phase++;
      enable = (en_mode == 1) || (en_mode == 2 && (en_phase % 4) == 0);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out at %0t", name, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_fifo [$];
  logic       m_wave [$];
  logic       exp_stx   = 1'b1;
  int         exp_count = 0;
  logic       exp_ovr   = 1'b0;
  logic       exp_busy  = 1'b0;

  // Whole frame as one line level per baud tick.
  task automatic buildFrame(input logic [7:0] d, input logic [7:0] lc);
    int n    = int'(lc[1:0]) + 5;
    int ones = 0;
    int stop_ticks;
    logic p;
    repeat (16) m_wave.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      ones += int'(d[i]);
      repeat (16) m_wave.push_back(d[i]);
    end
    if (lc[3]) begin
      if (lc[5])      p = ~lc[4];
      else if (lc[4]) p = (ones % 2) == 1;
      else            p = (ones % 2) == 0;
      repeat (16) m_wave.push_back(p);
    end
    stop_ticks = !lc[2] ? 16 : (n == 5 ? 24 : 32);
    repeat (stop_ticks) m_wave.push_back(1'b1);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fifo.delete();
      m_wave.delete();
      exp_stx   = 1'b1;
      exp_count = 0;
      exp_ovr   = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      if (enable) begin
        if (m_wave.size() > 0) void'(m_wave.pop_front());
        if (m_wave.size() == 0 && m_fifo.size() > 0) buildFrame(m_fifo.pop_front(), lcr);
      end
      exp_ovr = 1'b0;
      if (tf_push) begin
        if (m_fifo.size() < 16) m_fifo.push_back(tf_data_in);
        else exp_ovr = 1'b1;
      end
      exp_busy  = (m_wave.size() > 0);
      exp_stx   = lcr[6] ? 1'b0 : ((m_wave.size() > 0) ? m_wave[0] : 1'b1);
      exp_count = m_fifo.size();
    end
  end

  always @(negedge clk) begin
    checkOutput("model_stx", 32'(stx_pad_o), 32'(exp_stx));
    checkOutput("model_count", 32'(tf_count), 32'(exp_count));
    checkOutput("model_overrun", 32'(tf_overrun), 32'(exp_ovr));
    checkOutput("model_busy", 32'(tx_busy), 32'(exp_busy));
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic [7:0] d);
    @(posedge clk);
    #2;
    tf_push    = 1'b1;
    tf_data_in = d;
  endtask

  task automatic endPush();
    @(posedge clk);
    #2;
    tf_push = 1'b0;
  endtask

  // Waits for tx_busy to rise, then records stx per clock while busy.
  task automatic captureFrame(output int len);
    int guard = 0;
    len = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (tx_busy !== 1'b1 && guard < 300);
    if (tx_busy !== 1'b1) begin
      timeoutFail("busy_rise");
      return;
    end
    samples[0] = stx_pad_o;
    len = 1;
    forever begin
      @(negedge clk);
      if (tx_busy !== 1'b1) break;
      if (len >= 4096) begin
        timeoutFail("busy_fall");
        return;
      end
      samples[len] = stx_pad_o;
      len++;
    end
  endtask

  task automatic waitBusyRise();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (tx_busy !== 1'b1 && guard < 300);
    if (tx_busy !== 1'b1) timeoutFail("busy_rise_wait");
  endtask

  // Mid-bit samples of the first ten bit periods, bit 0 = start bit.
  function automatic logic [9:0] frame10();
    logic [9:0] v;
    for (int k = 0; k < 10; k++) v[k] = samples[16 * k + 8];
    return v;
  endfunction

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_stx", 32'(stx_pad_o), 32'd1);
    checkOutput("reset_count", 32'(tf_count), 32'd0);
    checkOutput("reset_overrun", 32'(tf_overrun), 32'd0);
    checkOutput("reset_busy", 32'(tx_busy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // 8N1, 0x55
    en_mode = 1;
    lcr = 8'h03;
    applyStimulus(8'h55);
    endPush();
    captureFrame(flen);
    checkOutput("8n1_len", 32'(flen), 32'd160);
    checkOutput("8n1_bits", 32'(frame10()), 32'h2AA);

    // 7E1 and 7O1, 0x41
    lcr = 8'h1A;
    applyStimulus(8'h41);
    endPush();
    captureFrame(flen);
    checkOutput("7e1_len", 32'(flen), 32'd160);
    checkOutput("7e1_bits", 32'(frame10()), 32'h282);
    lcr = 8'h0A;
    applyStimulus(8'h41);
    endPush();
    captureFrame(flen);
    checkOutput("7o1_bits", 32'(frame10()), 32'h382);

    // Long stop periods: 5-bit 1.5 stop and 8-bit 2 stop
    lcr = 8'h04;
    applyStimulus(8'h1F);
    endPush();
    captureFrame(flen);
    checkOutput("5n2_len", 32'(flen), 32'd120);
    lcr = 8'h07;
    applyStimulus(8'h1F);
    endPush();
    captureFrame(flen);
    checkOutput("8n2_len", 32'(flen), 32'd176);

    // Break during data bits of 0xFF
    lcr = 8'h03;
    applyStimulus(8'hFF);
    endPush();
    fork
      captureFrame(flen);
      begin
        waitBusyRise();
        repeat (40) @(negedge clk);
        lcr = 8'h43;
        @(negedge clk);
        checkOutput("break_low", 32'(stx_pad_o), 32'd0);
        lcr = 8'h03;
        @(negedge clk);
        checkOutput("break_release", 32'(stx_pad_o), 32'd1);
      end
    join
    checkOutput("break_len", 32'(flen), 32'd160);

    // Slow baud tick, 8 bits with stick-zero parity
    en_mode = 2;
    lcr = 8'h3B;
    applyStimulus(8'hC3);
    endPush();
    captureFrame(flen);
    checkOutput("slow_len", 32'(flen), 32'd704);

    // Fill with enable off: 17th push overruns
    en_mode = 0;
    lcr = 8'h03;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 17; i++) applyStimulus(8'(i * 29 + 3));
    endPush();
    checkOutput("fill_count", 32'(tf_count), 32'd16);
    checkOutput("fill_overrun", 32'(tf_overrun), 32'd1);
    @(posedge clk);
    #2;
    checkOutput("fill_overrun_clear", 32'(tf_overrun), 32'd0);
    en_mode = 1;
    captureFrame(flen);
    checkOutput("b2b_len", 32'(flen), 32'd2560);

    // Reset during data bit 3 of 0xA5 with one byte still queued
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    endPush();
    waitBusyRise();
    repeat (72) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_stx", 32'(stx_pad_o), 32'd1);
    checkOutput("midreset_count", 32'(tf_count), 32'd0);
    checkOutput("midreset_busy", 32'(tx_busy), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(8'h3C);
    endPush();
    captureFrame(flen);
    checkOutput("post_reset_len", 32'(flen), 32'd160);
    checkOutput("post_reset_bits", 32'(frame10()), 32'h278);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
